rf_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters. Port A is the single-cycle ALU writeback; port B is the multi-cycle load / mul-div writeback.
- Fixed priority to A, with an anti-starvation FSM that forces a B grant after MAX_WAIT consecutive losses.
- Registered output drives the register file's writeEnable/rd/data inputs directly, so write latency is 1 cycle after handshake.
- Writes to x0 are consumed but suppressed.

---
 rtl/rf_write_arbiter.sv | 112 +++++++++++
 tb/tb_rf_write_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file's single write port between the ALU writeback (A)
// and the load/mul-div writeback (B): fixed priority to A with forced B grants.
module rf_write_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             aValid,
    input  logic [4:0]       aRd,
    input  logic [31:0]      aData,
    output logic             aReady,
    input  logic             bValid,
    input  logic [4:0]       bRd,
    input  logic [31:0]      bData,
    output logic             bReady,
    output logic             writeEnable,
    output logic [4:0]       rd,
    output logic [31:0]      data,
    output logic             forcedB,
    output logic [CNT_W-1:0] conflictCount
);

    typedef enum logic {
        NORMAL  = 1'b0,
        FORCE_B = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [3:0] wait_cnt, wait_next;
    logic       a_xfer, b_xfer;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        aReady     = 1'b0;
        bReady     = 1'b0;
        state_next = state;
        wait_next  = wait_cnt;

        if (!reset) begin
            case (state)
                NORMAL: begin
                    aReady = aValid;
                    bReady = bValid && !aValid;
                end
                FORCE_B: bReady = bValid;
                default: ;
            endcase
        end

        if (!bValid || bReady) wait_next = 4'd0;
        else                   wait_next = wait_cnt + 4'd1;

        case (state)
            NORMAL: begin
                // The losing cycle that brings the count to MAX_WAIT arms the forced grant.
                if (bValid && !bReady && (wait_cnt + 4'd1 == 4'(MAX_WAIT))) begin
                    state_next = FORCE_B;
                    wait_next  = 4'd0;
                end
            end
            // FORCE_B lasts one cycle: either B transfers or B dropped its request.
            FORCE_B: state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    assign a_xfer  = aValid && aReady;
    assign b_xfer  = bValid && bReady;
    assign forcedB = (state == FORCE_B);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= NORMAL;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Registered write port: rd/data hold on idle cycles, x0 writes are swallowed.
    always_ff @(posedge clk) begin
        if (reset) begin
            writeEnable <= 1'b0;
            rd          <= 5'd0;
            data        <= 32'd0;
        end else if (a_xfer) begin
            writeEnable <= (aRd != 5'd0);
            rd          <= aRd;
            data        <= aData;
        end else if (b_xfer) begin
            writeEnable <= (bRd != 5'd0);
            rd          <= bRd;
            data        <= bData;
        end else begin
            writeEnable <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conflictCount <= '0;
        end else if (aValid && bValid && (conflictCount != {CNT_W{1'b1}})) begin
            conflictCount <= conflictCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter, checked against a
// cycle-level behavioural model of the grant rules kept in the bench.
module tb_rf_write_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 16;

    logic             clk;
    logic             reset;
    logic             aValid;
    logic [4:0]       aRd;
    logic [31:0]      aData;
    logic             aReady;
    logic             bValid;
    logic [4:0]       bRd;
    logic [31:0]      bData;
    logic             bReady;
    logic             writeEnable;
    logic [4:0]       rd;
    logic [31:0]      data;
    logic             forcedB;
    logic [CNT_W-1:0] conflictCount;

    rf_write_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .aValid(aValid), .aRd(aRd), .aData(aData), .aReady(aReady),
        .bValid(bValid), .bRd(bRd), .bData(bData), .bReady(bReady),
        .writeEnable(writeEnable), .rd(rd), .data(data),
        .forcedB(forcedB), .conflictCount(conflictCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: how many consecutive cycles B has been kept waiting,
    // plus the expected register-file port and conflict count.
    int          m_bwait;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_cnt;

    // Observations of the last cycle, for directed checks in the tests.
    logic obs_ar, obs_br, obs_fb, last_ga, last_gb;

    task automatic model_reset();
        m_bwait = 0;
        m_we    = 1'b0;
        m_rd    = 5'd0;
        m_data  = 32'd0;
        m_cnt   = 0;
    endtask

    // One clock cycle: entered just after a negedge, leaves just after the next negedge.
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bd);
        logic forced, ga, gb;
        aValid = av; aRd = ard; aData = ad;
        bValid = bv; bRd = brd; bData = bd;
        #1;
        forced = (m_bwait >= MAX_WAIT);
        ga = !forced && av;
        gb = bv && (forced || !av);
        obs_ar = aReady; obs_br = bReady; obs_fb = forcedB;
        checks++; if (aReady !== ga) begin errors++; $display("FAIL aReady got %b exp %b t=%0t", aReady, ga, $time); end
        checks++; if (bReady !== gb) begin errors++; $display("FAIL bReady got %b exp %b t=%0t", bReady, gb, $time); end
        checks++; if (forcedB !== forced) begin errors++; $display("FAIL forcedB got %b exp %b t=%0t", forcedB, forced, $time); end
        if (ga) begin
            m_we = (ard != 5'd0); m_rd = ard; m_data = ad;
        end else if (gb) begin
            m_we = (brd != 5'd0); m_rd = brd; m_data = bd;
        end else begin
            m_we = 1'b0;
        end
        m_bwait = (bv && !gb) ? m_bwait + 1 : 0;
        if (av && bv && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        @(posedge clk); #1;
        checks++; if (writeEnable !== m_we) begin errors++; $display("FAIL writeEnable got %b exp %b t=%0t", writeEnable, m_we, $time); end
        checks++; if (rd !== m_rd) begin errors++; $display("FAIL rd got %0d exp %0d t=%0t", rd, m_rd, $time); end
        checks++; if (data !== m_data) begin errors++; $display("FAIL data got %h exp %h t=%0t", data, m_data, $time); end
        checks++; if (conflictCount !== CNT_W'(m_cnt)) begin errors++; $display("FAIL conflictCount got %0d exp %0d t=%0t", conflictCount, m_cnt, $time); end
        last_ga = ga; last_gb = gb;
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Reset for one cycle with both requesters valid; no grants may appear.
    task automatic apply_reset();
        reset = 1'b1;
        aValid = 1'b1; aRd = 5'd9; aData = 32'h99;
        bValid = 1'b1; bRd = 5'd8; bData = 32'h88;
        #1;
        checks++; if (aReady !== 1'b0) begin errors++; $display("FAIL rst_aReady got %b exp 0", aReady); end
        checks++; if (bReady !== 1'b0) begin errors++; $display("FAIL rst_bReady got %b exp 0", bReady); end
        @(posedge clk); #1;
        model_reset();
        checks++; if (writeEnable !== 1'b0) begin errors++; $display("FAIL rst_writeEnable got %b exp 0", writeEnable); end
        checks++; if (rd !== 5'd0) begin errors++; $display("FAIL rst_rd got %0d exp 0", rd); end
        checks++; if (data !== 32'd0) begin errors++; $display("FAIL rst_data got %h exp 0", data); end
        checks++; if (forcedB !== 1'b0) begin errors++; $display("FAIL rst_forcedB got %b exp 0", forcedB); end
        checks++; if (conflictCount !== '0) begin errors++; $display("FAIL rst_conflictCount got %0d exp 0", conflictCount); end
        @(negedge clk);
        reset = 1'b0;
        aValid = 1'b0; bValid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        idle();
    endtask

    task automatic test_a_only();
        cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        checks++; if (obs_ar !== 1'b1) begin errors++; $display("FAIL a_only_ready got %b exp 1", obs_ar); end
        checks++; if ({writeEnable, rd, data} !== {1'b1, 5'd5, 32'h1234})
            begin errors++; $display("FAIL a_only_write got %b/%0d/%h exp 1/5/1234", writeEnable, rd, data); end
        idle();
    endtask

    task automatic test_conflict_once();
        cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB);
        checks++; if (rd !== 5'd3 || writeEnable !== 1'b1) begin errors++; $display("FAIL conflict_first got rd %0d we %b exp 3/1", rd, writeEnable); end
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'hB);
        checks++; if (rd !== 5'd4 || data !== 32'hB || writeEnable !== 1'b1) begin errors++; $display("FAIL conflict_second got rd %0d data %h exp 4/b", rd, data); end
        checks++; if (conflictCount !== 16'd1) begin errors++; $display("FAIL conflict_count got %0d exp 1", conflictCount); end
        idle();
    endtask

    task automatic test_starvation();
        for (int i = 0; i < MAX_WAIT; i++) begin
            cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'hB7);
            checks++; if (obs_br !== 1'b0 || obs_fb !== 1'b0) begin errors++; $display("FAIL starve_wait%0d got bReady %b forcedB %b exp 0/0", i, obs_br, obs_fb); end
        end
        cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'hB7);
        checks++; if ({obs_fb, obs_br, obs_ar} !== 3'b110) begin errors++; $display("FAIL starve_force got fb/br/ar %b%b%b exp 110", obs_fb, obs_br, obs_ar); end
        checks++; if (rd !== 5'd7) begin errors++; $display("FAIL starve_rd got %0d exp 7", rd); end
        cycle(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'd0);
        checks++; if (obs_fb !== 1'b0 || obs_ar !== 1'b1) begin errors++; $display("FAIL starve_back got fb %b ar %b exp 0/1", obs_fb, obs_ar); end
        idle();
    endtask

    task automatic test_force_drop();
        for (int i = 0; i < MAX_WAIT; i++) cycle(1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h66);
        cycle(1'b1, 5'd2, 32'h22, 1'b0, 5'd6, 32'h66);
        checks++; if ({obs_fb, obs_br, obs_ar, writeEnable} !== 4'b1000) begin errors++; $display("FAIL drop got fb/br/ar/we %b%b%b%b exp 1000", obs_fb, obs_br, obs_ar, writeEnable); end
        cycle(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0);
        checks++; if (obs_ar !== 1'b1) begin errors++; $display("FAIL drop_recover got aReady %b exp 1", obs_ar); end
        idle();
    endtask

    task automatic test_x0();
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
        checks++; if (obs_br !== 1'b1 || writeEnable !== 1'b0) begin errors++; $display("FAIL x0_b got br %b we %b exp 1/0", obs_br, writeEnable); end
        cycle(1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'd0);
        checks++; if (obs_ar !== 1'b1 || writeEnable !== 1'b0) begin errors++; $display("FAIL x0_a got ar %b we %b exp 1/0", obs_ar, writeEnable); end
        idle();
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 5'd9, 32'h9999, 1'b1, 5'd10, 32'hAAAA);
        apply_reset();
        checks++; if (writeEnable !== 1'b0 || rd !== 5'd0) begin errors++; $display("FAIL reset_mid got we %b rd %0d exp 0/0", writeEnable, rd); end
        idle();
    endtask

    task automatic test_random();
        logic av, bv;
        logic [4:0] ar, br;
        logic [31:0] ad, bd;
        av = 1'b0; bv = 1'b0; ar = '0; br = '0; ad = '0; bd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!av && $urandom_range(0, 99) < 60) begin
                av = 1'b1; ar = 5'($urandom_range(0, 31)); ad = $urandom;
            end
            if (!bv && $urandom_range(0, 99) < 50) begin
                bv = 1'b1; br = 5'($urandom_range(0, 31)); bd = $urandom;
            end
            cycle(av, ar, ad, bv, br, bd);
            if (last_ga) av = 1'b0;
            if (last_gb) bv = 1'b0;
        end
        idle();
    endtask

    task automatic test_saturation();
        localparam int N = (1 << CNT_W) + 5;
        int b_grants;
        logic [31:0] ad, bd;
        apply_reset();
        b_grants = 0;
        ad = $urandom; bd = $urandom;
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, 5'd12, ad, 1'b1, 5'd13, bd);
            if (last_ga) ad = $urandom;
            if (last_gb) begin bd = $urandom; b_grants++; end
        end
        checks++; if (conflictCount !== 16'hFFFF) begin errors++; $display("FAIL sat_count got %h exp ffff", conflictCount); end
        checks++; if (b_grants !== N / (MAX_WAIT + 1)) begin errors++; $display("FAIL sat_bgrants got %0d exp %0d", b_grants, N / (MAX_WAIT + 1)); end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        aValid = 1'b0; aRd = '0; aData = '0;
        bValid = 1'b0; bRd = '0; bData = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_a_only();
        test_conflict_once();
        test_starvation();
        test_force_drop();
        test_x0();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
